// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, counter
// widths and the lock-loss counter width.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK    = 2'd0,
    STAGE_MEM    = 2'd1,
    STAGE_PERIPH = 2'd2,
    RUN          = 2'd3
  } state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  // Counters compare against N-1, so $clog2(N) bits suffice; N<2 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by an optional debouncer; CYCLES=0 gives the
// synchronized level directly.
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (CYCLES == 0) begin : g_sync_only
      assign o_level = r_sync2;
    end else begin : g_debounce
      localparam int unsigned CW = cnt_width(CYCLES);
      localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_level;

      // Counts consecutive samples that disagree with the current level;
      // any agreeing sample restarts the run.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_level = r_level;
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (memory, peripherals, core) gated on stable PLL lock,
// with abort on lock loss or debounced button and a saturating loss counter.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned DEBOUNCE_CYCLES    = 96000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  btn_rst,
  output logic                  rst_mem,
  output logic                  rst_periph,
  output logic                  rst_core,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned GW = cnt_width(STAGE_GAP);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);

  logic w_lock_s;
  logic w_btn_db;

  sync_debounce #(.CYCLES(0)) u_lock_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (pll_lock),
    .o_level (w_lock_s)
  );

  sync_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (btn_rst),
    .o_level (w_btn_db)
  );

  state_t                r_state;
  logic [SW-1:0]         r_stable_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_rst_mem;
  logic                  r_rst_periph;
  logic                  r_rst_core;
  logic                  r_ready;

  state_t                w_state_nxt;
  logic [SW-1:0]         w_stable_nxt;
  logic [GW-1:0]         w_gap_nxt;
  logic [LOSS_CNT_W-1:0] w_loss_nxt;
  logic                  w_abort;

  always_comb begin
    w_state_nxt  = r_state;
    w_stable_nxt = '0;
    w_gap_nxt    = '0;
    w_loss_nxt   = r_loss_cnt;
    w_abort      = (r_state != WAIT_LOCK) && (!w_lock_s || w_btn_db);

    if (w_abort) begin
      w_state_nxt = WAIT_LOCK;
      // Lock loss wins over a simultaneous button press for counting.
      if (!w_lock_s && (r_loss_cnt != '1)) begin
        w_loss_nxt = r_loss_cnt + 1'b1;
      end
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (w_lock_s && !w_btn_db) begin
            if (r_stable_cnt == STABLE_LAST) begin
              w_state_nxt = STAGE_MEM;
            end else begin
              w_stable_nxt = r_stable_cnt + 1'b1;
            end
          end
        end
        STAGE_MEM: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = STAGE_PERIPH;
          end else begin
            w_gap_nxt = r_gap_cnt + 1'b1;
          end
        end
        STAGE_PERIPH: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = RUN;
          end else begin
            w_gap_nxt = r_gap_cnt + 1'b1;
          end
        end
        RUN: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // Outputs are registered alongside the state, decoded from the next state,
  // so they change on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT_LOCK;
      r_stable_cnt <= '0;
      r_gap_cnt    <= '0;
      r_loss_cnt   <= '0;
      r_rst_mem    <= 1'b1;
      r_rst_periph <= 1'b1;
      r_rst_core   <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_loss_cnt   <= w_loss_nxt;
      r_rst_mem    <= (w_state_nxt == WAIT_LOCK);
      r_rst_periph <= (w_state_nxt == WAIT_LOCK) || (w_state_nxt == STAGE_MEM);
      r_rst_core   <= (w_state_nxt != RUN);
      r_ready      <= (w_state_nxt == RUN);
    end
  end

  assign rst_mem       = r_rst_mem;
  assign rst_periph    = r_rst_periph;
  assign rst_core      = r_rst_core;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed latency checks plus a
// time-based reference model compared every cycle under random stimulus.
module tb_reset_sequencer;

  localparam int LOCK = 8;
  localparam int GAP  = 4;
  localparam int DEB  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       btn_rst;
  logic       rst_mem;
  logic       rst_periph;
  logic       rst_core;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model: m_seq is edges elapsed since the first release (-1 = held).
  int   m_seq;
  int   m_stable;
  int   m_cnt;
  int   m_brun;
  logic m_l1, m_l2, m_b1, m_b2, m_db;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(LOCK),
    .STAGE_GAP         (GAP),
    .DEBOUNCE_CYCLES   (DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .btn_rst      (btn_rst),
    .rst_mem      (rst_mem),
    .rst_periph   (rst_periph),
    .rst_core     (rst_core),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {rst_mem, rst_periph, rst_core, ready, lock_loss_cnt};

  task automatic model_step();
    logic ls, bd;
    if (reset) begin
      m_seq = -1; m_stable = 0; m_cnt = 0; m_brun = 0;
      m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0; m_db = 0;
    end else begin
      ls = m_l2;
      bd = m_db;
      if (m_seq >= 0 && (!ls || bd)) begin
        m_seq = -1;
        m_stable = 0;
        if (!ls && m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (m_seq < 0) begin
        if (ls && !bd) begin
          m_stable = m_stable + 1;
          if (m_stable == LOCK) begin
            m_seq = 0;
            m_stable = 0;
          end
        end else begin
          m_stable = 0;
        end
      end else if (m_seq < 2 * GAP) begin
        m_seq = m_seq + 1;
      end
      if (m_b2 == m_db) m_brun = 0;
      else m_brun = m_brun + 1;
      if (m_brun == DEB) begin
        m_db = m_b2;
        m_brun = 0;
      end
      m_l2 = m_l1; m_l1 = pll_lock;
      m_b2 = m_b1; m_b1 = btn_rst;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    return {m_seq < 0, m_seq < GAP, m_seq < 2 * GAP, m_seq >= 2 * GAP, 8'(m_cnt)};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; pll_lock = 1'b0; btn_rst = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b0; btn_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs !== 12'hE00) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, 12'hE00);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if (obs !== 12'hE00) begin
        errors++;
        $display("FAIL reset_nolock cyc=%0d got=%h want=%h", i, obs, 12'hE00);
      end
    end
  endtask

  task automatic test_release();
    int t_mem = 0, t_per = 0, t_core = 0, t_rdy = 0;
    do_reset();
    pll_lock = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL release_model edge=%0d got=%h want=%h", e, obs, exp_vec());
      end
      if (t_mem == 0 && rst_mem === 1'b0) t_mem = e;
      if (t_per == 0 && rst_periph === 1'b0) t_per = e;
      if (t_core == 0 && rst_core === 1'b0) t_core = e;
      if (t_rdy == 0 && ready === 1'b1) t_rdy = e;
    end
    checks++;
    if (t_mem != 10 || t_per != 14 || t_core != 18 || t_rdy != 18) begin
      errors++;
      $display("FAIL release_timing got=%0d/%0d/%0d/%0d want=10/14/18/18", t_mem, t_per, t_core, t_rdy);
    end
  endtask

  task automatic test_glitch();
    int t_mem = 0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      pll_lock = (e != 8);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model edge=%0d got=%h want=%h", e, obs, exp_vec());
      end
      if (t_mem == 0 && rst_mem === 1'b0) t_mem = e;
    end
    checks++;
    if (t_mem != 18 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch_timing got=%0d cnt=%0d want=18 cnt=0", t_mem, lock_loss_cnt);
    end
  endtask

  task automatic test_lock_loss();
    do_reset();
    for (int it = 1; it <= 300; it++) begin
      int n = 0;
      int t = 0;
      pll_lock = 1'b1;
      while (ready !== 1'b1 && n < 100) begin
        cycle();
        n++;
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL lockloss_relock it=%0d got=%h want=%h", it, obs, exp_vec());
        end
      end
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL lockloss_ready_timeout it=%0d got=%b want=1", it, ready);
      end
      repeat ($urandom_range(0, 5)) begin
        cycle();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL lockloss_run it=%0d got=%h want=%h", it, obs, exp_vec());
        end
      end
      pll_lock = 1'b0;
      for (int e = 1; e <= 4; e++) begin
        cycle();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL lockloss_drop it=%0d edge=%0d got=%h want=%h", it, e, obs, exp_vec());
        end
        if (t == 0 && ready === 1'b0) t = e;
      end
      checks++;
      if (t != 3 || {rst_mem, rst_periph, rst_core} !== 3'b111) begin
        errors++;
        $display("FAIL lockloss_latency it=%0d got=%0d rst=%b want=3 rst=111", it, t, {rst_mem, rst_periph, rst_core});
      end
      repeat ($urandom_range(0, 3)) cycle();
      checks++;
      if (lock_loss_cnt !== 8'((it > 255) ? 255 : it)) begin
        errors++;
        $display("FAIL lockloss_count it=%0d got=%0d want=%0d", it, lock_loss_cnt, (it > 255) ? 255 : it);
      end
    end
  endtask

  task automatic test_button();
    int n = 0;
    int t = 0;
    logic [7:0] bounce = 8'b0011_0011;
    do_reset();
    pll_lock = 1'b1;
    while (ready !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL button_ready_timeout got=%b want=1", ready);
    end
    for (int i = 0; i < 8; i++) begin
      btn_rst = bounce[i];
      cycle();
      checks++;
      if (ready !== 1'b1 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL button_bounce i=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    btn_rst = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL button_hold edge=%0d got=%h want=%h", e, obs, exp_vec());
      end
      if (t == 0 && ready === 1'b0) t = e;
    end
    checks++;
    if (t != 8 || lock_loss_cnt !== 8'd0 || rst_mem !== 1'b1) begin
      errors++;
      $display("FAIL button_abort got=%0d cnt=%0d mem=%b want=8 cnt=0 mem=1", t, lock_loss_cnt, rst_mem);
    end
    btn_rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      cycle();
      n++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL button_recover got=%h want=%h", obs, exp_vec());
      end
    end
    checks++;
    if (n != 7 + LOCK + 2 * GAP) begin
      errors++;
      $display("FAIL button_recover_time got=%0d want=%0d", n, 7 + LOCK + 2 * GAP);
    end
  endtask

  task automatic test_lock_and_button();
    int n = 0;
    do_reset();
    pll_lock = 1'b1;
    while (ready !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    btn_rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 6) pll_lock = 1'b0;
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL both_model edge=%0d got=%h want=%h", e, obs, exp_vec());
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL both_count got=%0d rdy=%b want=1 rdy=0", lock_loss_cnt, ready);
    end
    btn_rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      pll_lock = 1'b1;
      while (ready !== 1'b1 && n < 100) begin
        cycle();
        n++;
      end
      pll_lock = 1'b0;
      repeat (3) cycle();
    end
    pll_lock = 1'b1;
    n = 0;
    while (rst_periph !== 1'b0 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (lock_loss_cnt !== 8'd3 || rst_core !== 1'b1 || rst_periph !== 1'b0) begin
      errors++;
      $display("FAIL midreset_setup got=%h want cnt=3 periph=0 core=1", obs);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (obs !== 12'hE00) begin
      errors++;
      $display("FAIL midreset got=%h want=%h", obs, 12'hE00);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int lock_left = 0;
    int btn_left = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (lock_left == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        lock_left = $urandom_range(1, 40);
      end
      if (btn_left == 0) begin
        btn_rst = ($urandom_range(0, 3) == 0);
        btn_left = $urandom_range(1, 12);
      end
      lock_left--;
      btn_left--;
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_lock_loss();
    test_button();
    test_lock_and_button();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
